// File: rtl/hex_display_scanner.sv
// Multiplexed common-anode seven-segment scanner with frame-aligned word
// promotion, leading-zero blanking and whole-display status glyphs.

module seven_segment (
  input  logic [3:0] value,
  output logic [6:0] segments
);
  // Active-low, bit 6 = g ... bit 0 = a.
  always_comb begin
    unique case (value)
      4'h0: segments = 7'b1000000;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      default: segments = 7'b0001110;
    endcase
  end
endmodule

module hex_display_scanner #(
  parameter int DIGITS        = 4,
  parameter int PRESCALE      = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [1:0]            load_flags,
  output logic [6:0]            hex,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam int WW = 4 * DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
  localparam logic [6:0] GLYPH_H = 7'b0001001;
  localparam logic [6:0] GLYPH_U = 7'b1000001;

  typedef enum logic {OFF, SCAN} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WW-1:0]     active, active_n, pending, pending_n;
  logic [1:0]        aflags, aflags_n, pflags, pflags_n;
  logic              pending_full, pending_full_n;
  logic              promote, transfer, frame_end, drive;
  logic [IW-1:0]     top_nz;
  logic [3:0]        nibble;
  logic [6:0]        seg, glyph, hex_d;
  logic [DIGITS-1:0] sel_d;

  assign promote    = frame_done || (state == OFF);
  assign load_ready = !pending_full || promote;
  assign transfer   = load_valid && load_ready;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    frame_end = 1'b0;
    case (state)
      OFF: begin
        if (enable) begin
          state_n = SCAN;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_n = OFF;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (idx == LAST_IDX) begin
            idx_n     = '0;
            frame_end = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = OFF;
    endcase
  end

  always_comb begin
    active_n       = active;
    aflags_n       = aflags;
    pending_n      = pending;
    pflags_n       = pflags;
    pending_full_n = pending_full;
    if (promote && pending_full) begin
      active_n       = pending;
      aflags_n       = pflags;
      pending_full_n = 1'b0;
    end
    if (transfer) begin
      pending_n      = load_value;
      pflags_n       = load_flags;
      pending_full_n = 1'b1;
    end
  end

  always_comb begin
    top_nz = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (active_n[4*i +: 4] != 4'h0) top_nz = IW'(i);
    end
  end

  assign nibble = active_n[4*idx_n +: 4];

  seven_segment u_seg (
    .value    (nibble),
    .segments (seg)
  );

  // Pins are computed from next-cycle state so they line up with the counter.
  always_comb begin
    drive = (state_n == SCAN) && (cnt_n != '0);
    if (aflags_n[1])      glyph = GLYPH_H;
    else if (aflags_n[0]) glyph = GLYPH_U;
    else if ((BLANK_LEADING != 0) && (idx_n != '0) && (idx_n > top_nz)) glyph = '1;
    else                  glyph = seg;
    hex_d = drive ? glyph : '1;
    sel_d = drive ? ~(DIGITS'(1) << idx_n) : '1;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state        <= OFF;
      idx          <= '0;
      cnt          <= '0;
      active       <= '0;
      aflags       <= '0;
      pending      <= '0;
      pflags       <= '0;
      pending_full <= 1'b0;
      hex          <= '1;
      digit_sel    <= '1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      active       <= active_n;
      aflags       <= aflags_n;
      pending      <= pending_n;
      pflags       <= pflags_n;
      pending_full <= pending_full_n;
      hex          <= hex_d;
      digit_sel    <= sel_d;
      frame_done   <= frame_end;
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner (DIGITS=4, PRESCALE=4), with a
// second instance that has leading-zero blanking disabled.

module tb_hex_display_scanner;
  logic        clock, nReset, enable, load_valid;
  logic [15:0] load_value;
  logic [1:0]  load_flags;
  logic        load_ready, load_ready_nb;
  logic [6:0]  hex, hex_nb;
  logic [3:0]  digit_sel, sel_nb;
  logic        frame_done, fd_nb;

  int asserts = 0;
  int errors  = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] hex;
    logic [6:0] hex_nb;
    logic       fd;
  } exp_t;
  exp_t sb[$];

  hex_display_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_LEADING(1)) dut (
    .clock(clock), .nReset(nReset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_value(load_value), .load_flags(load_flags),
    .hex(hex), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  hex_display_scanner #(.DIGITS(4), .PRESCALE(4), .BLANK_LEADING(0)) dut_nb (
    .clock(clock), .nReset(nReset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready_nb), .load_value(load_value), .load_flags(load_flags),
    .hex(hex_nb), .digit_sel(sel_nb), .frame_done(fd_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_glyph(input logic [15:0] w, input logic [1:0] f,
                                           input int i, input bit blank);
    int hi;
    hi = 0;
    for (int j = 0; j < 4; j++) if (w[j*4 +: 4] != 4'h0) hi = j;
    if (f[1]) return 7'h09;
    if (f[0]) return 7'h41;
    if (blank && i > 0 && i > hi) return 7'h7F;
    return seg7(w[i*4 +: 4]);
  endfunction

  // Sample k counts cycles since entering SCAN from OFF (k=0 is the first dead cycle).
  task automatic push_range(input logic [15:0] w, input logic [1:0] f, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      int c;
      int i;
      exp_t e;
      c = k % 4;
      i = (k / 4) % 4;
      if (c != 0) begin
        e.sel    = ~(4'b0001 << i);
        e.hex    = exp_glyph(w, f, i, 1'b1);
        e.hex_nb = exp_glyph(w, f, i, 1'b0);
      end else begin
        e.sel    = 4'hF;
        e.hex    = 7'h7F;
        e.hex_nb = 7'h7F;
      end
      e.fd = (k > 0) && (k % 16 == 0);
      sb.push_back(e);
    end
  endtask

  task automatic load_off(input logic [15:0] w, input logic [1:0] f);
    int n;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    load_value = w;
    load_flags = f;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    asserts++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_handshake: load_ready=%b after %0d cycles, expected 1", load_ready, n);
    end
    @(negedge clock);
    load_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    nReset = 1'b0; enable = 1'b0; load_valid = 1'b0; load_value = '0; load_flags = '0;
    repeat (3) @(negedge clock);
    nReset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      asserts++;
      if ({hex, digit_sel, load_ready, frame_done, hex_nb, sel_nb} !== {7'h7F, 4'hF, 1'b1, 1'b0, 7'h7F, 4'hF}) begin
        errors++;
        $display("FAIL reset_idle k=%0d: hex=%b sel=%b ready=%b fd=%b, expected hex=1111111 sel=1111 ready=1 fd=0",
                 k, hex, digit_sel, load_ready, frame_done);
      end
    end
  endtask

  task automatic scan_word(input logic [15:0] w, input logic [1:0] f, input int last_k, input string tag);
    exp_t e;
    load_off(w, f);
    enable = 1'b1;
    push_range(w, f, 0, last_k);
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done, sel_nb, hex_nb, fd_nb} !== {e.sel, e.hex, e.fd, e.sel, e.hex_nb, e.fd}) begin
        errors++;
        $display("FAIL %s k=%0d: sel=%b hex=%b fd=%b sel_nb=%b hex_nb=%b fd_nb=%b, expected sel=%b hex=%b hex_nb=%b fd=%b",
                 tag, k, digit_sel, hex, frame_done, sel_nb, hex_nb, fd_nb, e.sel, e.hex, e.hex_nb, e.fd);
      end
    end
  endtask

  task automatic test_digits;
    scan_word(16'h1234, 2'b00, 32, "digits_1234");
  endtask

  task automatic test_blanking;
    scan_word(16'h0050, 2'b00, 16, "blank_0050");
  endtask

  task automatic test_flags;
    for (int t = 1; t < 4; t++) begin
      logic [1:0] f;
      f = 2'(t);
      scan_word(16'h1234, f, 16, "flags");
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    load_off(16'h1234, 2'b00);
    enable = 1'b1;
    push_range(16'h1234, 2'b00, 0, 16);
    push_range(16'hAAAA, 2'b00, 17, 32);
    push_range(16'hBBBB, 2'b00, 33, 48);
    for (int k = 0; k <= 48; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done, sel_nb, hex_nb, fd_nb} !== {e.sel, e.hex, e.fd, e.sel, e.hex_nb, e.fd}) begin
        errors++;
        $display("FAIL back_to_back k=%0d: sel=%b hex=%b fd=%b, expected sel=%b hex=%b fd=%b",
                 k, digit_sel, hex, frame_done, e.sel, e.hex, e.fd);
      end
      if (k == 6 || k == 15 || k == 16 || k == 17 || k == 32 || k == 33) begin
        asserts++;
        if (load_ready !== ((k == 16 || k == 32 || k == 33) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL back_to_back_ready k=%0d: load_ready=%b, expected %b",
                   k, load_ready, (k == 16 || k == 32 || k == 33));
        end
      end
      if (k == 5) begin
        load_value = 16'hAAAA; load_valid = 1'b1;
      end
      if (k == 6) load_value = 16'hBBBB;
      if (k == 17) load_valid = 1'b0;
    end
  endtask

  task automatic test_enable_drop;
    exp_t e;
    load_off(16'h1234, 2'b00);
    enable = 1'b1;
    push_range(16'h1234, 2'b00, 0, 9);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done} !== {e.sel, e.hex, e.fd}) begin
        errors++;
        $display("FAIL enable_drop_pre k=%0d: sel=%b hex=%b fd=%b, expected sel=%b hex=%b fd=%b",
                 k, digit_sel, hex, frame_done, e.sel, e.hex, e.fd);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      asserts++;
      if ({digit_sel, hex, frame_done} !== {4'hF, 7'h7F, 1'b0}) begin
        errors++;
        $display("FAIL enable_drop_off k=%0d: sel=%b hex=%b fd=%b, expected sel=1111 hex=1111111 fd=0",
                 k, digit_sel, hex, frame_done);
      end
    end
    enable = 1'b1;
    push_range(16'h1234, 2'b00, 0, 16);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done} !== {e.sel, e.hex, e.fd}) begin
        errors++;
        $display("FAIL enable_restart k=%0d: sel=%b hex=%b fd=%b, expected sel=%b hex=%b fd=%b",
                 k, digit_sel, hex, frame_done, e.sel, e.hex, e.fd);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    load_off(16'h1234, 2'b00);
    enable = 1'b1;
    push_range(16'h1234, 2'b00, 0, 6);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done} !== {e.sel, e.hex, e.fd}) begin
        errors++;
        $display("FAIL async_pre k=%0d: sel=%b hex=%b fd=%b, expected sel=%b hex=%b fd=%b",
                 k, digit_sel, hex, frame_done, e.sel, e.hex, e.fd);
      end
      if (k == 4) begin
        load_value = 16'h5555; load_valid = 1'b1;
      end
      if (k == 5) load_valid = 1'b0;
    end
    nReset = 1'b0;
    enable = 1'b0;
    #1;
    asserts++;
    if ({hex, digit_sel, frame_done, load_ready} !== {7'h7F, 4'hF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: hex=%b sel=%b fd=%b ready=%b, expected hex=1111111 sel=1111 fd=0 ready=1",
               hex, digit_sel, frame_done, load_ready);
    end
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    repeat (2) @(negedge clock);
    // Pending 5555 must have been discarded and the active word cleared.
    enable = 1'b1;
    push_range(16'h0000, 2'b00, 0, 16);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clock);
      e = sb.pop_front();
      asserts++;
      if ({digit_sel, hex, frame_done, sel_nb, hex_nb} !== {e.sel, e.hex, e.fd, e.sel, e.hex_nb}) begin
        errors++;
        $display("FAIL async_post k=%0d: sel=%b hex=%b hex_nb=%b fd=%b, expected sel=%b hex=%b hex_nb=%b fd=%b",
                 k, digit_sel, hex, hex_nb, frame_done, e.sel, e.hex, e.hex_nb, e.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blanking();
    test_back_to_back();
    test_flags();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end
endmodule
